add64_seq_ctrl: RTL
===================

Name: add64_seq_ctrl

Overview:
- Sequencer that performs a 64-bit add/sub, or a 32-bit RV64 ADDW/SUBW, on one shared 16-bit carry-lookahead adder by iterating over 16-bit chunks.
- Sits between the EX-stage issue logic (valid/ready in) and writeback (valid/ready out).
- Drives the external adder's x/y/cin inputs and captures f/cout, chaining the carry chunk to chunk.
- Area-saving alternative to a full 64-bit adder for low-cost configurations.

Parameters:
- XLEN, 64, operand/result width.
- CHUNK_W, 16, adder slice width; fixed to match the shared adder; XLEN and 32 must be multiples of it.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B.
- sub  in  1  1 = A - B (B inverted, cin = 1).
- word  in  1  1 = 32-bit op, result sign-extended from bit 31.
- flush  in  1  pipeline flush; aborts any operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  sum/difference.
- carry_out  out  1  carry out of the top processed chunk (0 = borrow on sub).
- overflow  out  1  signed overflow of the selected width.
- cla_x  out  CHUNK_W  to adder x.
- cla_y  out  CHUNK_W  to adder y.
- cla_cin  out  1  to adder cin.
- cla_f  in  CHUNK_W  adder sum (combinational return).
- cla_cout  in  1  adder carry out.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state <= IDLE.
  - in_ready = 1, out_valid = 0, result = 0, carry_out = 0, overflow = 0.
  - cla_x/cla_y/cla_cin = 0.
  - Chunk counter and carry register cleared.
- States: IDLE, RUN, DONE; in_ready = (state == IDLE).
- IDLE:
  - When in_valid & in_ready at edge T: latch A and B' (B' = sub ? ~op_b : op_b), latch word.
  - carry <= sub, idx <= 0, result cleared, go to RUN.
- RUN (one chunk per cycle):
  - cla_x = A[idx], cla_y = B'[idx], cla_cin = carry.
  - At the edge: result[idx] <= cla_f, carry <= cla_cout, idx <= idx + 1.
  - Last chunk is idx 3 (64-bit) or idx 1 (word). After it, go to DONE.
  - On entering DONE, the carry_out and overflow registers are loaded from the last chunk.
- Sign extension in word mode: on the last-chunk edge, result[63:32] <= replicate(cla_f[15]).
- Overflow: (A[msb] == B'[msb]) && (sum[msb] != A[msb]), with msb = 63, or 31 in word mode.
- Latency: request accepted at edge T; RUN occupies cycles T+1 .. T+4 (64-bit) or T+1 .. T+2 (word); out_valid is high from cycle T+5 or T+3 respectively.
- DONE:
  - out_valid = 1; result, carry_out and overflow are held stable while out_ready = 0.
  - out_valid & out_ready at an edge -> IDLE.
  - No new request is accepted in the same cycle, so the minimum issue interval is 6 cycles (64-bit) or 4 cycles (word).
- Outside RUN: cla_x/cla_y/cla_cin are driven 0.
- flush:
  - Sampled at every edge; any state -> IDLE.
  - out_valid drops the next cycle, the in-flight result is discarded, idx and carry are cleared.
  - flush has priority over in_valid: a request presented together with flush is not accepted.
- Reset asserted mid-operation behaves like flush and also clears the output registers.
- The chunk counter wraps only via the state transition; idx never exceeds the last-chunk index.

Test Plan:
- 64-bit add, A = 0x0000_0000_0000_FFFF, B = 1, sub = 0 -> cla_cin = 1 during RUN cycle 2; result 0x0000_0000_0001_0000, carry_out 0, overflow 0; out_valid rises exactly at T+5.
- 64-bit sub, A = 0, B = 1 -> result 0xFFFF_FFFF_FFFF_FFFF, carry_out 0, overflow 0. Also A = 5, B = 5 -> result 0, carry_out 1.
- Signed overflow, A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, add -> result 0x8000_0000_0000_0000, overflow 1, carry_out 0.
- Word mode, A = 0x1234_5678_7FFF_FFFF, B = 1, word = 1 -> result 0xFFFF_FFFF_8000_0000, overflow 1; out_valid at T+3; only 2 RUN cycles.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> out_valid, result and flags stable, in_ready 0; raise out_ready -> next cycle IDLE, in_ready 1.
- Flush and reset:
  - flush in the 2nd RUN cycle -> next cycle IDLE, out_valid never asserts, cla_* = 0.
  - flush with in_valid in IDLE -> request not accepted.
  - rst_n low mid-RUN -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/add64_seq_ctrl.sv
// Sequencer for 64-bit add/sub and RV64 ADDW/SUBW on one shared CHUNK_W-bit adder.
// Processes one chunk per cycle, chaining the carry through a register.
module add64_seq_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  input  logic               sub,
  input  logic               word,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               carry_out,
  output logic               overflow,
  output logic [CHUNK_W-1:0] cla_x,
  output logic [CHUNK_W-1:0] cla_y,
  output logic               cla_cin,
  input  logic [CHUNK_W-1:0] cla_f,
  input  logic               cla_cout
);

  localparam int unsigned NCHUNK = XLEN / CHUNK_W;
  localparam int unsigned WCHUNK = 32 / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_D = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(WCHUNK - 1);
  localparam int unsigned MSB = CHUNK_W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic                word_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic                last_chunk;
  logic [CHUNK_W-1:0]  a_chunk;
  logic [CHUNK_W-1:0]  b_chunk;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (IDX_W'(i) == idx_q) begin
        a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
        b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  assign last_chunk = (idx_q == (word_q ? LAST_W : LAST_D));

  always_comb begin
    cla_x   = '0;
    cla_y   = '0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      cla_x   = a_chunk;
      cla_y   = b_chunk;
      cla_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      word_q    <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= sub ? ~op_b : op_b;
            word_q   <= word;
            carry_q  <= sub;
            idx_q    <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Word mode sign-extends the upper chunks on the same edge as the last sum chunk.
          for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (IDX_W'(i) == idx_q)
              result[i*CHUNK_W +: CHUNK_W] <= cla_f;
            else if (word_q && last_chunk && i >= WCHUNK)
              result[i*CHUNK_W +: CHUNK_W] <= {CHUNK_W{cla_f[MSB]}};
          end
          carry_q <= cla_cout;
          if (last_chunk) begin
            idx_q     <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            carry_out <= cla_cout;
            overflow  <= (a_chunk[MSB] == b_chunk[MSB]) && (cla_f[MSB] != a_chunk[MSB]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
